// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot streaming encoder and related priority logic.
package onehot_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PRIO_LSB = 0;
    localparam int PRIO_MSB = 1;

endpackage : onehot_pkg

// File: rtl/onehot_prio_enc.sv
// Combinational priority encoder: winning bit index plus hit/multi-hot flags.
// Also usable as the grant-index stage of an arbiter.
module onehot_prio_enc
    import onehot_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = PRIO_LSB
) (
    input  logic [2**N-1:0] i_data,
    output logic [N-1:0]    o_idx,
    output logic            o_hit,
    output logic            o_multi
);

    localparam int W = 2**N;

    always_comb begin
        o_idx = '0;
        // The last assignment in loop order is the winner.
        if (MODE == PRIO_LSB) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (i_data[i]) o_idx = N'(i);
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                if (i_data[i]) o_idx = N'(i);
            end
        end
    end

    assign o_hit   = |i_data;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign o_multi = |(i_data & (i_data - W'(1)));

endmodule : onehot_prio_enc

// File: rtl/onehot_enc_stream.sv
// Streaming one-hot to binary encoder with valid/ready on both sides, a 2-entry
// skid buffer (main + skid) and a saturating bad-word counter.
//
// state | meaning
// EMPTY | no entry held; out_valid=0, in_ready=1
// BUSY  | main holds the output entry; in_ready=1
// FULL  | main and skid both hold entries; in_ready=0
module onehot_enc_stream
    import onehot_pkg::*;
#(
    parameter int N         = 4,
    parameter int MODE      = PRIO_LSB,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [2**N-1:0]      i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [N-1:0]         o_out_idx,
    output logic                 o_out_hit,
    output logic                 o_out_multi,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    input  logic                 i_clr_err
);

    typedef struct packed {
        logic [N-1:0] idx;
        logic         hit;
        logic         multi;
    } entry_t;

    state_t               r_state;
    state_t               w_state_nxt;
    entry_t               r_main;
    entry_t               r_skid;
    entry_t               w_enc;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [N-1:0]         w_enc_idx;
    logic                 w_enc_hit;
    logic                 w_enc_multi;
    logic                 w_in_xfer;
    logic                 w_bad;
    logic                 w_load_main;
    logic                 w_main_from_skid;
    logic                 w_load_skid;

    onehot_prio_enc #(
        .N    (N),
        .MODE (MODE)
    ) u_enc (
        .i_data  (i_in_data),
        .o_idx   (w_enc_idx),
        .o_hit   (w_enc_hit),
        .o_multi (w_enc_multi)
    );

    assign w_enc     = '{idx: w_enc_idx, hit: w_enc_hit, multi: w_enc_multi};
    assign w_in_xfer = i_in_valid && r_in_ready;
    assign w_bad     = w_in_xfer && (!w_enc.hit || w_enc.multi);

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = BUSY;
                    w_load_main = 1'b1;
                end
            end
            BUSY: begin
                if (w_in_xfer && i_out_ready) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (i_out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (i_out_ready) begin
                    w_state_nxt      = BUSY;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            if (w_load_main) begin
                r_main <= w_enc;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_enc;
            end
            if (i_clr_err) begin
                r_err_cnt <= w_bad ? ERR_CNT_W'(1) : '0;
            end else if (w_bad && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_idx   = r_main.idx;
    assign o_out_hit   = r_main.hit;
    assign o_out_multi = r_main.multi;
    assign o_err_cnt   = r_err_cnt;

endmodule : onehot_enc_stream

// File: doc/onehot_enc_stream.md
Name: onehot_enc_stream

Overview:
Streaming one-hot to binary encoder with a valid/ready handshake on both sides and a 2-entry skid buffer, so in_ready comes straight from a register. Input priority is selectable: LSB-first or MSB-first. Each word is flagged as no-hit or multi-hot, and a saturating error counter tracks bad words. It sits between a one-hot source (grant vector, decoded flags) and any consumer that wants an index, and it tolerates backpressure.

Parameters:
N, 4, output index width; input width is 2**N
MODE, 0, priority selection: 0 = lowest set bit wins, 1 = highest set bit wins
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word; registered
in_data  input  2**N  one-hot input word
out_valid  output  1  output entry valid
out_ready  input  1  consumer accepts the output entry
out_idx  output  N  encoded index of the winning bit
out_hit  output  1  at least one input bit was set
out_multi  output  1  more than one input bit was set
err_cnt  output  ERR_CNT_W  saturating count of accepted words with out_hit=0 or out_multi=1
clr_err  input  1  clears err_cnt

Behaviour:
- Single clock; rst is synchronous and active-high.
- Reset values:
  - state EMPTY, in_ready=1, out_valid=0.
  - out_idx=0, out_hit=0, out_multi=0, err_cnt=0.
  - in_valid is ignored while rst=1.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Encoding:
  - Encoding is combinational on in_data before storage; an entry is {idx, hit, multi}.
  - MODE=0: idx = lowest set bit position. MODE=1: idx = highest set bit position.
  - in_data=0: idx=0, hit=0, multi=0.
  - multi=1 iff popcount(in_data) >= 2.
- Latency: 1 cycle. A word accepted at edge k is presented from edge k (out_valid high the cycle after the transfer cycle) when the buffer was EMPTY, or BUSY with out_ready=1.
- Storage: main register drives the outputs; skid register holds one overflow entry.
- State machine:
  - EMPTY (out_valid=0, in_ready=1): input transfer -> BUSY, main loaded.
  - BUSY (out_valid=1, in_ready=1):
    - input transfer and out_ready -> BUSY, main reloaded with the new entry.
    - input transfer and !out_ready -> FULL, skid loaded, main held.
    - no input transfer and out_ready -> EMPTY.
    - otherwise hold.
  - FULL (out_valid=1, in_ready=0): out_ready -> BUSY, main <= skid. No input is accepted in FULL.
- Ordering: strict FIFO order; no loss or duplication under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, out_idx, out_hit and out_multi hold stable.
- Error counter:
  - Increments by 1 on each input transfer whose entry has hit=0 or multi=1.
  - Saturates at 2**ERR_CNT_W-1.
  - clr_err=1 alone -> 0 next cycle.
  - clr_err=1 in the same cycle as an error transfer -> 1.
- Reset mid-operation: both entries are discarded and every output returns to its reset value on the next edge.

Decomposition:
- Package onehot_pkg:
  - state typedef enum logic [1:0] {EMPTY, BUSY, FULL}.
  - Constants PRIO_LSB=0 and PRIO_MSB=1.
- One combinational sub-module, onehot_prio_enc (parameters N and MODE):
  - input in_data; outputs idx, hit, multi.
  - Also reusable by arbiters.
- The top holds the FSM, the main/skid registers and the counter.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> in_ready=1, out_valid=0, out_idx=0, err_cnt=0.
- Single word, N=4, MODE=0: in_data=16'h0020, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_hit=1, out_multi=0; err_cnt stays 0.
- Multi-hot priority:
  - in_data=16'h8012 with MODE=0 -> out_idx=1, out_multi=1, err_cnt=1.
  - Same word with MODE=1 -> out_idx=15.
- Backpressure: out_ready=0, in_valid held, words 16'h0001, 16'h0002, 16'h0004 -> first two accepted, state FULL, in_ready=0, third held off; raise out_ready -> out_idx sequence 0, 1, 2, with no gaps or duplicates.
- Zero word and saturation: ERR_CNT_W=2, five accepted 16'h0000 words -> out_hit=0, out_idx=0, err_cnt=3 (saturated); then clr_err=1 -> 0; clr_err together with an error word -> 1.
- Reset mid-FULL: reach FULL, assert rst for 1 cycle -> out_valid=0, in_ready=1, out_idx=0; held entries are never emitted afterwards.
